mult_div_unit: RTL

// - Iterative multiply/divide unit for the multicycle MIPS datapath; successor to the fixed 32-bit Multiply block.
// - Parametrised width; performs MULT, MULTU, DIV and DIVU with a Start/Done handshake.
// - Results go to HI/LO and are read through the MemtoReg mux (MFHI/MFLO); the UC waits on Done instead of decoding states.

---
 rtl/mult_div_pkg.sv | 29 ++
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and sign-fix helper for the iterative multiply/divide unit.
package mult_div_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } md_op_t;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      RUN,
      FIX,
      DONE
   } md_state_t;

   localparam int MD_MAX_W = 128;

   // Two's-complement negate of the low w bits of x; bits at and above w are cleared.
   function automatic logic [MD_MAX_W-1:0] negate(input logic [MD_MAX_W-1:0] x, input int w);
      logic [MD_MAX_W-1:0] mask;
      mask = '1;
      if (w < MD_MAX_W) mask = ~({MD_MAX_W{1'b1}} << w);
      return (~x + MD_MAX_W'(1)) & mask;
   endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with Start/Done handshake; Done WIDTH+3 cycles after Start (2 on divide-by-zero).
// No backpressure: Start is accepted only in IDLE and is otherwise dropped; Hi/Lo hold until the next result.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             DivZero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int W2    = 2 * WIDTH;

   md_state_t        state, state_nxt;
   md_op_t           op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] addend;
   logic [W2-1:0]    acc;
   logic [WIDTH-1:0] rem;
   logic [CNT_W-1:0] cnt;
   logic             neg_p, neg_r;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             dz_q;

   logic             is_div, is_signed, s_a, s_b, div_by_zero, last_iter;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   mul_sum, mul_top;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_sub;
   logic             div_ge;
   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   // Operand conditioning, one iteration step and the final sign fixes.
   always_comb begin
      is_div      = op_q[1];
      is_signed   = ~op_q[0];
      s_a         = is_signed & a_q[WIDTH-1];
      s_b         = is_signed & b_q[WIDTH-1];
      mag_a       = s_a ? WIDTH'(negate(MD_MAX_W'(a_q), WIDTH)) : a_q;
      mag_b       = s_b ? WIDTH'(negate(MD_MAX_W'(b_q), WIDTH)) : b_q;
      div_by_zero = is_div && (b_q == '0);
      last_iter   = (cnt == CNT_W'(WIDTH - 1));

      mul_sum     = {1'b0, acc[W2-1:WIDTH]} + {1'b0, addend};
      mul_top     = acc[0] ? mul_sum : {1'b0, acc[W2-1:WIDTH]};

      div_shift   = {rem, acc[WIDTH-1]};
      div_ge      = (div_shift >= {1'b0, addend});
      div_sub     = div_shift[WIDTH-1:0] - addend;

      prod_fix    = neg_p ? W2'(negate(MD_MAX_W'(acc), W2)) : acc;
      quo_fix     = neg_p ? WIDTH'(negate(MD_MAX_W'(acc[WIDTH-1:0]), WIDTH)) : acc[WIDTH-1:0];
      rem_fix     = neg_r ? WIDTH'(negate(MD_MAX_W'(rem), WIDTH)) : rem;
   end

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Start) state_nxt = PREP;
         PREP:    state_nxt = div_by_zero ? DONE : RUN;
         RUN:     if (last_iter) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Busy = 1'b0;
      Done = 1'b0;
      case (state)
         PREP, RUN, FIX: Busy = 1'b1;
         DONE:           Done = 1'b1;
         default:        ;
      endcase
   end

   // In RUN the low half of acc holds the multiplier (MULT) or the dividend/quotient (DIV).
   always_ff @(posedge Clk) begin
      if (Reset) begin
         op_q   <= OP_MULT;
         a_q    <= '0;
         b_q    <= '0;
         addend <= '0;
         acc    <= '0;
         rem    <= '0;
         cnt    <= '0;
         neg_p  <= 1'b0;
         neg_r  <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         dz_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  op_q <= md_op_t'(Op);
                  a_q  <= A;
                  b_q  <= B;
                  dz_q <= 1'b0;
               end
            end
            PREP: begin
               addend <= is_div ? mag_b : mag_a;
               acc    <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
               rem    <= '0;
               cnt    <= '0;
               neg_p  <= s_a ^ s_b;
               neg_r  <= s_a;
               if (div_by_zero) begin
                  hi_q <= a_q;
                  lo_q <= '1;
                  dz_q <= 1'b1;
               end
            end
            RUN: begin
               cnt <= cnt + CNT_W'(1);
               if (is_div) begin
                  acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ge};
                  rem            <= div_ge ? div_sub : div_shift[WIDTH-1:0];
               end else begin
                  acc <= {mul_top, acc[WIDTH-1:1]};
               end
            end
            FIX: begin
               if (is_div) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end else begin
                  hi_q <= prod_fix[W2-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign Hi      = hi_q;
   assign Lo      = lo_q;
   assign DivZero = dz_q;

endmodule
